// File: rtl/demux_4ch_collector.sv
`default_nettype none
// ============================================================================
//  Module   : demux_4ch_collector
//  Purpose  : Collects words from the four outputs of a 1:4 demultiplexer into
//             four independent per-channel FIFOs. The FIFOs are drained onto a
//             single output stream by a round-robin arbiter. A sticky flag
//             records any accepted input on which a non-selected channel was
//             non-zero.
//  Ports    : clk, rst                - clock, synchronous active-high reset
//             out0..out3, sel         - demux channel words and their select
//             in_valid / in_ready     - input handshake (targets FIFO[sel])
//             out_valid / out_ready   - output handshake
//             out_data, out_chan      - presented word and its channel index
//             ch_full                 - per-channel FIFO full flags
//             iso_err                 - sticky channel-isolation error
//  Revision : 1.0  initial release
// ============================================================================
module demux_4ch_collector #(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] out0,
  input  logic [3:0] out1,
  input  logic [3:0] out2,
  input  logic [3:0] out3,
  input  logic [1:0] sel,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_data,
  output logic [1:0] out_chan,
  output logic [3:0] ch_full,
  output logic       iso_err
);

  localparam int unsigned c_aw = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [c_aw:0] c_ptr_one = {{c_aw{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [c_aw:0] r_wptr [4];
  logic [c_aw:0] r_rptr [4];
  logic [3:0]    r_mem  [4][DEPTH];
  logic [1:0]    r_rr_ptr;
  logic          r_iso_err;

  logic [3:0] w_in    [4];
  logic [3:0] w_empty;
  logic [3:0] w_full;
  logic [1:0] w_grant;
  logic       w_any;
  logic       w_push;
  logic       w_pop;
  logic       w_others_nz;

  assign w_in[0] = out0;
  assign w_in[1] = out1;
  assign w_in[2] = out2;
  assign w_in[3] = out3;

  generate
    for (genvar g = 0; g < 4; g++) begin : g_ch_flags
      assign w_empty[g] = (r_wptr[g] == r_rptr[g]);
      assign w_full[g]  = (r_wptr[g][c_aw] != r_rptr[g][c_aw]) &&
                          (r_wptr[g][c_aw-1:0] == r_rptr[g][c_aw-1:0]);
    end
  endgenerate

  // Round-robin search: walk offsets from the highest down so the smallest
  // offset from r_rr_ptr that is non-empty is the final winner.
  always_comb begin
    logic [1:0] w_idx;
    w_grant = 2'd0;
    w_any   = 1'b0;
    w_idx   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      w_idx = r_rr_ptr + 2'(i);
      if (!w_empty[w_idx]) begin
        w_grant = w_idx;
        w_any   = 1'b1;
      end
    end
  end

  always_comb begin
    w_others_nz = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if ((2'(i) != sel) && (w_in[i] != 4'd0)) begin
        w_others_nz = 1'b1;
      end
    end
  end

  // Full blocks a push even when the same channel pops on this edge.
  assign in_ready  = ~w_full[sel];
  assign w_push    = in_valid & in_ready;
  assign out_valid = w_any;
  assign w_pop     = w_any & out_ready;

  assign out_data = w_any ? r_mem[w_grant][r_rptr[w_grant][c_aw-1:0]] : 4'd0;
  assign out_chan = w_any ? w_grant : 2'd0;
  assign ch_full  = w_full;
  assign iso_err  = r_iso_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
      end
      r_rr_ptr  <= 2'd0;
      r_iso_err <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr[sel] <= r_wptr[sel] + c_ptr_one;
        if (w_others_nz) begin
          r_iso_err <= 1'b1;
        end
      end
      if (w_pop) begin
        r_rptr[w_grant] <= r_rptr[w_grant] + c_ptr_one;
        r_rr_ptr        <= w_grant + 2'd1;
      end
    end
  end

  // Storage needs no reset: empty FIFOs never present their contents.
  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      r_mem[sel][r_wptr[sel][c_aw-1:0]] <= w_in[sel];
    end
  end

endmodule
`default_nettype wire
